rx_byte_pack: RTL

RX_BYTE_PACK -- requirements
Module: rx_byte_pack

---
 rtl/rx_byte_pack.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rx_byte_pack.sv
// Receive byte packer: strips a GMII-style preamble/SFD and packs the frame's
// data bytes big-endian into 32-bit words tagged with sop/eop/mod/err.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   din, din_vld      received byte and its valid (high across the whole frame)
//   din_err           PHY error for the current byte
//   dout, dout_vld    packed word and its valid strobe (registered)
//   dout_sop/eop      first / last word of a frame
//   dout_mod          on eop, number of zero-padded low bytes
//   dout_err          on eop, frame saw din_err
module rx_byte_pack #(
  parameter logic [7:0] PRE_BYTE = 8'h55,
  parameter logic [7:0] SFD_BYTE = 8'hD5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        din_err,
  output logic [31:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic [1:0]  dout_mod,
  output logic        dout_err
);

  localparam int unsigned W_WORD = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [W_WORD-1:0]   r_acc, w_acc_nxt, w_acc_ins;
  logic [1:0]          r_cnt, w_cnt_nxt;
  logic [W_WORD-1:0]   r_hold, w_hold_nxt;
  logic                r_hold_vld, w_hold_vld_nxt;
  logic                r_first, w_first_nxt;
  logic                r_err, w_err_nxt;

  logic                w_emit, w_emit_sop, w_emit_eop, w_emit_err;
  logic [1:0]          w_emit_mod;
  logic [W_WORD-1:0]   w_emit_word;

  logic [W_WORD-1:0]   r_dout;
  logic                r_dout_vld, r_dout_sop, r_dout_eop, r_dout_err;
  logic [1:0]          r_dout_mod;

  // Accumulator with the current byte dropped into the next big-endian slot
  always_comb begin
    w_acc_ins = r_acc;
    case (r_cnt)
      2'd0:    w_acc_ins[31:24] = din;
      2'd1:    w_acc_ins[23:16] = din;
      2'd2:    w_acc_ins[15:8]  = din;
      default: w_acc_ins[7:0]   = din;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= DROP;
    else     r_state <= w_state_nxt;
  end

  // Next-state, datapath update and word emission
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_first_nxt    = r_first;
    w_err_nxt      = r_err;
    w_emit         = 1'b0;
    w_emit_word    = r_hold;
    w_emit_sop     = 1'b0;
    w_emit_eop     = 1'b0;
    w_emit_mod     = 2'd0;
    w_emit_err     = 1'b0;

    case (r_state)
      IDLE: begin
        // Idle cycle doubles as per-frame cleanup
        w_acc_nxt      = '0;
        w_cnt_nxt      = 2'd0;
        w_hold_vld_nxt = 1'b0;
        w_first_nxt    = 1'b1;
        w_err_nxt      = 1'b0;
        if (din_vld) begin
          w_err_nxt   = din_err;
          w_state_nxt = (din == PRE_BYTE) ? PRE : DROP;
        end
      end

      PRE: begin
        if (!din_vld) begin
          w_state_nxt = IDLE;
        end else begin
          w_err_nxt = r_err | din_err;
          if (din == PRE_BYTE)      w_state_nxt = PRE;
          else if (din == SFD_BYTE) w_state_nxt = DATA;
          else                      w_state_nxt = DROP;
        end
      end

      DATA: begin
        if (din_vld) begin
          w_err_nxt = r_err | din_err;
          // A held word is only released once more data proves it is not last
          if (r_hold_vld) begin
            w_emit         = 1'b1;
            w_emit_word    = r_hold;
            w_emit_sop     = r_first;
            w_first_nxt    = 1'b0;
            w_hold_vld_nxt = 1'b0;
          end
          if (r_cnt == 2'd3) begin
            w_hold_nxt     = w_acc_ins;
            w_hold_vld_nxt = 1'b1;
            w_acc_nxt      = '0;
          end else begin
            w_acc_nxt = w_acc_ins;
          end
          w_cnt_nxt = r_cnt + 2'd1;
        end else begin
          w_state_nxt = IDLE;
          // Hold and a partial accumulator are never both occupied
          if (r_hold_vld) begin
            w_emit      = 1'b1;
            w_emit_word = r_hold;
            w_emit_mod  = 2'd0;
          end else if (r_cnt != 2'd0) begin
            w_emit      = 1'b1;
            w_emit_word = r_acc;
            w_emit_mod  = 2'(3'd4 - {1'b0, r_cnt});
          end
          w_emit_sop = w_emit & r_first;
          w_emit_eop = w_emit;
          w_emit_err = w_emit & r_err;
        end
      end

      default: begin
        if (!din_vld) w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= 2'd0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_first    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_first    <= w_first_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Output registers; dout keeps its last value between words
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_dout_sop <= 1'b0;
      r_dout_eop <= 1'b0;
      r_dout_mod <= 2'd0;
      r_dout_err <= 1'b0;
    end else begin
      r_dout_vld <= w_emit;
      r_dout_sop <= w_emit_sop;
      r_dout_eop <= w_emit_eop;
      r_dout_mod <= w_emit_mod;
      r_dout_err <= w_emit_err;
      if (w_emit) r_dout <= w_emit_word;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign dout_sop = r_dout_sop;
  assign dout_eop = r_dout_eop;
  assign dout_mod = r_dout_mod;
  assign dout_err = r_dout_err;

endmodule
